keylock_ctrl: RTL and testbench

Parametrised keypad lock controller. It owns the code-entry buffer, the stored user code, code reprogramming, blink timing and failed-attempt lockout internally; the previous controller relied on external match, valid-code and blink-done inputs for these. It sits between the keypad debouncer/encoder (`rdy`, `keypress`) and the board LEDs/lock actuator.

---
 rtl/keylock_pkg.sv | 52 +++++
 rtl/keylock_if.sv | 14 +
 rtl/keylock_entry_buf.sv | 68 ++++++
 rtl/keylock_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_keylock_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keylock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keylock_pkg
//  Description : Shared types, default key codes and the key classifier used
//                by the keypad lock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package keylock_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_PROG_OLD  = 3'd2,
        ST_PROG_NEW  = 3'd3,
        ST_PROG_CONF = 3'd4,
        ST_OK        = 3'd5,
        ST_ERR       = 3'd6,
        ST_LOCKOUT   = 3'd7
    } state_t;

    // Classification of a strobed key
    typedef enum logic [2:0] {
        KC_NONE   = 3'd0,
        KC_DIGIT  = 3'd1,
        KC_ENTER  = 3'd2,
        KC_PROG   = 3'd3,
        KC_CANCEL = 3'd4
    } key_class_t;

    localparam int c_CANCEL_KEY_DEF = 7;
    localparam int c_PROG_KEY_DEF   = 8;
    localparam int c_ENTER_KEY_DEF  = 9;

    // Keys above 9 are never meaningful; command keys take priority over digits.
    function automatic key_class_t key_class(
        input logic [3:0] key,
        input logic [3:0] enter_k,
        input logic [3:0] prog_k,
        input logic [3:0] cancel_k
    );
        key_class_t kc;
        if (key > 4'd9)           kc = KC_NONE;
        else if (key == enter_k)  kc = KC_ENTER;
        else if (key == prog_k)   kc = KC_PROG;
        else if (key == cancel_k) kc = KC_CANCEL;
        else                      kc = KC_DIGIT;
        return kc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keylock_if.sv
`default_nettype none
// ============================================================================
//  Module      : keylock_if
//  Description : Key strobe bus from the keypad encoder to the lock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keylock_if;
    logic       rdy;
    logic [3:0] keypress;

    modport master (output rdy, output keypress);
    modport slave  (input  rdy, input  keypress);
endinterface
`default_nettype wire

// File: rtl/keylock_entry_buf.sv
`default_nettype none
// ============================================================================
//  Module      : keylock_entry_buf
//  Description : Code-entry shift buffer with saturating digit count, overflow
//                flag and comparator against a reference code.
//  Revision    : 1.0 - initial release
// ============================================================================
module keylock_entry_buf #(
    parameter int DIGITS = 4
) (
    input  wire                  clk,
    input  wire                  resetN,
    input  wire                  i_clear,
    input  wire                  i_shift,
    input  wire [3:0]            i_digit,
    input  wire [4*DIGITS-1:0]   i_ref,
    output logic                 o_match,
    output logic                 o_full,
    output logic [4*DIGITS-1:0]  o_buf
);

    localparam int c_CW = $clog2(DIGITS + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DIGITS);

    logic [4*DIGITS-1:0] r_buf;
    logic [c_CW-1:0]     r_cnt;
    logic                r_ovf;
    logic [4*DIGITS-1:0] w_shifted;
    logic [4*DIGITS-1:0] w_first;

    assign w_first = (4*DIGITS)'(i_digit);

    generate
        if (DIGITS == 1) begin : g_single
            assign w_shifted = i_digit;
        end else begin : g_multi
            assign w_shifted = {r_buf[4*DIGITS-5:0], i_digit};
        end
    endgenerate

    // Clear on state exit; a digit arriving with the clear becomes the first digit
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_ovf <= 1'b0;
            if (i_shift) begin
                r_buf <= w_first;
                r_cnt <= c_CW'(1);
            end else begin
                r_buf <= '0;
                r_cnt <= '0;
            end
        end else if (i_shift) begin
            r_buf <= w_shifted;
            if (r_cnt == c_FULL) r_ovf <= 1'b1;
            else                 r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_full  = (r_cnt == c_FULL) && !r_ovf;
    assign o_match = o_full && (r_buf == i_ref);
    assign o_buf   = r_buf;

endmodule
`default_nettype wire

// File: rtl/keylock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keylock_ctrl
//  Description : Keypad lock controller: code entry, reprogramming, OK/ERR
//                blink timing and optional failed-attempt lockout.
//                Define KEYLOCK_LOCKOUT_EN to build the failure counter and
//                LOCKOUT state; otherwise every failure goes to ERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module keylock_ctrl
    import keylock_pkg::*;
#(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] RESET_CODE  = 16'h1234,
    parameter int                  ENTER_KEY   = c_ENTER_KEY_DEF,
    parameter int                  PROG_KEY    = c_PROG_KEY_DEF,
    parameter int                  CANCEL_KEY  = c_CANCEL_KEY_DEF,
    parameter int                  BLINK_CYC   = 50_000_000,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCKOUT_CYC = 500_000_000
) (
    input  wire        clk,
    input  wire        resetN,
    keylock_if.slave   key_if,
    output logic       locked,
    output logic       led_entry,
    output logic       led_prog,
    output logic       led_ok,
    output logic       led_err,
    output logic       lockout,
    output logic       busy,
    output logic [3:0] fail_cnt
);

    localparam int c_TMAX = (BLINK_CYC > LOCKOUT_CYC) ? BLINK_CYC : LOCKOUT_CYC;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_BLINK_LD = c_TW'(BLINK_CYC - 1);
    localparam logic [3:0] c_ENTER  = 4'(ENTER_KEY);
    localparam logic [3:0] c_PROG   = 4'(PROG_KEY);
    localparam logic [3:0] c_CANCEL = 4'(CANCEL_KEY);

    state_t              r_state;
    state_t              w_next;
    state_t              w_fail_dest;
    key_class_t          w_kc;
    logic [c_TW-1:0]     r_timer;
    logic                r_locked;
    logic [4*DIGITS-1:0] r_code;
    logic [4*DIGITS-1:0] r_cand;
    logic [4*DIGITS-1:0] w_ref;
    logic [4*DIGITS-1:0] w_buf;
    logic                w_match;
    logic                w_full;
    logic                w_clear;
    logic                w_shift;
    logic                w_toggle;
    logic                w_latch;
    logic                w_commit;
`ifdef KEYLOCK_LOCKOUT_EN
    localparam logic [c_TW-1:0] c_LOCK_LD = c_TW'(LOCKOUT_CYC - 1);
    localparam logic [3:0]      c_MAX     = 4'(MAX_TRIES);
    logic       w_fail;
    logic [3:0] r_fail_cnt;
    logic [3:0] w_fail_inc;
`endif

    assign w_kc  = key_if.rdy ? key_class(key_if.keypress, c_ENTER, c_PROG, c_CANCEL) : KC_NONE;
    assign w_ref = (r_state == ST_PROG_CONF) ? r_cand : r_code;

`ifdef KEYLOCK_LOCKOUT_EN
    assign w_fail_inc  = (r_fail_cnt < c_MAX) ? r_fail_cnt + 4'd1 : r_fail_cnt;
    assign w_fail_dest = (w_fail_inc == c_MAX) ? ST_LOCKOUT : ST_ERR;
`else
    assign w_fail_dest = ST_ERR;
`endif

    keylock_entry_buf #(
        .DIGITS (DIGITS)
    ) u_buf (
        .clk     (clk),
        .resetN  (resetN),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_digit (key_if.keypress),
        .i_ref   (w_ref),
        .o_match (w_match),
        .o_full  (w_full),
        .o_buf   (w_buf)
    );

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode and one-cycle action strobes
    always_comb begin
        w_next   = r_state;
        w_shift  = 1'b0;
        w_toggle = 1'b0;
        w_latch  = 1'b0;
        w_commit = 1'b0;
`ifdef KEYLOCK_LOCKOUT_EN
        w_fail   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                case (w_kc)
                    KC_ENTER: w_next = ST_ENTRY;
                    KC_DIGIT: begin
                        w_next  = ST_ENTRY;
                        w_shift = 1'b1;
                    end
                    KC_PROG:  w_next = r_locked ? ST_ERR : ST_PROG_OLD;
                    default:  ;
                endcase
            end
            ST_ENTRY, ST_PROG_OLD, ST_PROG_NEW, ST_PROG_CONF: begin
                if (w_kc == KC_DIGIT) begin
                    w_shift = 1'b1;
                end else if (w_kc == KC_CANCEL) begin
                    w_next = ST_IDLE;
                end else if (r_state == ST_ENTRY && w_kc == KC_ENTER) begin
                    if (w_match) begin
                        w_next   = ST_OK;
                        w_toggle = 1'b1;
                    end else begin
                        w_next = w_fail_dest;
`ifdef KEYLOCK_LOCKOUT_EN
                        w_fail = 1'b1;
`endif
                    end
                end else if (r_state == ST_PROG_OLD && w_kc == KC_PROG) begin
                    if (w_match) begin
                        w_next = ST_PROG_NEW;
                    end else begin
                        w_next = w_fail_dest;
`ifdef KEYLOCK_LOCKOUT_EN
                        w_fail = 1'b1;
`endif
                    end
                end else if (r_state == ST_PROG_NEW && w_kc == KC_PROG) begin
                    w_latch = w_full;
                    w_next  = w_full ? ST_PROG_CONF : ST_ERR;
                end else if (r_state == ST_PROG_CONF && w_kc == KC_PROG) begin
                    w_commit = w_match;
                    w_next   = w_match ? ST_OK : ST_ERR;
                end
            end
            ST_OK, ST_ERR, ST_LOCKOUT: begin
                if (r_timer == '0) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_clear = (w_next != r_state);

    // Indication timer loads on state entry and counts down while held
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_timer <= '0;
        end else if (w_clear) begin
            case (w_next)
                ST_OK, ST_ERR: r_timer <= c_BLINK_LD;
`ifdef KEYLOCK_LOCKOUT_EN
                ST_LOCKOUT:    r_timer <= c_LOCK_LD;
`endif
                default:       r_timer <= '0;
            endcase
        end else if (r_timer != '0) begin
            r_timer <= r_timer - c_TW'(1);
        end
    end

    // Lock state, programming candidate and stored code
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_locked <= 1'b0;
            r_cand   <= '0;
            r_code   <= RESET_CODE;
        end else begin
            if (w_toggle) r_locked <= ~r_locked;
            if (w_latch)  r_cand   <= w_buf;
            if (w_commit) r_code   <= r_cand;
        end
    end

`ifdef KEYLOCK_LOCKOUT_EN
    // Consecutive failures: cleared by any success or at the end of lockout
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_fail_cnt <= 4'd0;
        end else if (w_clear && (w_next == ST_OK || r_state == ST_LOCKOUT)) begin
            r_fail_cnt <= 4'd0;
        end else if (w_fail) begin
            r_fail_cnt <= w_fail_inc;
        end
    end

    assign fail_cnt = r_fail_cnt;
    assign lockout  = (r_state == ST_LOCKOUT);
`else
    assign fail_cnt = 4'd0;
    assign lockout  = 1'b0;
`endif

    assign locked    = r_locked;
    assign led_entry = (r_state == ST_ENTRY);
    assign led_prog  = (r_state == ST_PROG_OLD) || (r_state == ST_PROG_NEW) ||
                       (r_state == ST_PROG_CONF);
    assign led_ok    = (r_state == ST_OK);
    assign led_err   = (r_state == ST_ERR) || (r_state == ST_LOCKOUT);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keylock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keylock_ctrl
//  Description : Self-checking bench for keylock_ctrl (table plus sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keylock_ctrl;

`ifdef KEYLOCK_LOCKOUT_EN
    localparam int c_LK = 1;
`else
    localparam int c_LK = 0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       locked, led_entry, led_prog, led_ok, led_err, lockout, busy;
    logic [3:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    keylock_if kif ();

    keylock_ctrl #(
        .DIGITS      (4),
        .RESET_CODE  (16'h1234),
        .ENTER_KEY   (9),
        .PROG_KEY    (8),
        .CANCEL_KEY  (7),
        .BLINK_CYC   (4),
        .MAX_TRIES   (3),
        .LOCKOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .key_if    (kif),
        .locked    (locked),
        .led_entry (led_entry),
        .led_prog  (led_prog),
        .led_ok    (led_ok),
        .led_err   (led_err),
        .lockout   (lockout),
        .busy      (busy),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [3:0]  key;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [10:0] outs();
        return {locked, led_entry, led_prog, led_ok, led_err, lockout, busy, fail_cnt};
    endfunction

    // Expected output word with lockout=0 and fail_cnt=0
    function automatic logic [10:0] e(input logic lk, input logic en, input logic pr,
                                      input logic ok, input logic er, input logic bz);
        return {lk, en, pr, ok, er, 1'b0, bz, 4'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        kif.rdy      = 1'b1;
        kif.keypress = k;
        @(negedge clk);
        kif.rdy      = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code, input logic [3:0] term);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
        press(term);
    endtask

    function automatic logic ind(input int sel);
        case (sel)
            0:       return led_ok;
            1:       return led_err;
            default: return lockout;
        endcase
    endfunction

    // Count cycles the indication stays up; optionally hold ENTER strobed throughout
    task automatic measure(input string name, input int sel, input int exp_len, input logic hold);
        int n = 0;
        if (hold) begin
            kif.rdy      = 1'b1;
            kif.keypress = 4'd9;
        end
        while (ind(sel) && n < 100) begin
            n++;
            @(negedge clk);
        end
        kif.rdy = 1'b0;
        chk(name, n, exp_len);
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'd1,  e(0,1,0,0,0,1)};
        tbl[1]  = '{1'b1, 4'd2,  e(0,1,0,0,0,1)};
        tbl[2]  = '{1'b1, 4'd3,  e(0,1,0,0,0,1)};
        tbl[3]  = '{1'b1, 4'd4,  e(0,1,0,0,0,1)};
        tbl[4]  = '{1'b1, 4'd9,  e(1,0,0,1,0,1)};
        tbl[5]  = '{1'b0, 4'd0,  e(1,0,0,1,0,1)};
        tbl[6]  = '{1'b1, 4'd2,  e(1,0,0,1,0,1)};
        tbl[7]  = '{1'b1, 4'd1,  e(1,0,0,1,0,1)};
        tbl[8]  = '{1'b1, 4'd9,  e(1,0,0,0,0,0)};
        tbl[9]  = '{1'b1, 4'd5,  e(1,1,0,0,0,1)};
        tbl[10] = '{1'b1, 4'd7,  e(1,0,0,0,0,0)};
        tbl[11] = '{1'b1, 4'd9,  e(1,1,0,0,0,1)};
        tbl[12] = '{1'b1, 4'd1,  e(1,1,0,0,0,1)};
        tbl[13] = '{1'b1, 4'd2,  e(1,1,0,0,0,1)};
        tbl[14] = '{1'b1, 4'd3,  e(1,1,0,0,0,1)};
        tbl[15] = '{1'b1, 4'd4,  e(1,1,0,0,0,1)};
        tbl[16] = '{1'b1, 4'd9,  e(0,0,0,1,0,1)};
        tbl[17] = '{1'b0, 4'd0,  e(0,0,0,1,0,1)};
        tbl[18] = '{1'b0, 4'd0,  e(0,0,0,1,0,1)};
        tbl[19] = '{1'b0, 4'd0,  e(0,0,0,1,0,1)};
        tbl[20] = '{1'b1, 4'd9,  e(0,0,0,0,0,0)};
        tbl[21] = '{1'b1, 4'd12, e(0,0,0,0,0,0)};
        tbl[22] = '{1'b1, 4'd8,  e(0,0,1,0,0,1)};
        tbl[23] = '{1'b1, 4'd7,  e(0,0,0,0,0,0)};

        resetN       = 1'b0;
        kif.rdy      = 1'b0;
        kif.keypress = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 11'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs(), 11'd0);

        // Table: unlock, expiry vs key, cancel, relock, ignored key, PROG/CANCEL
        for (int i = 0; i < 24; i++) begin
            kif.rdy      = tbl[i].rdy;
            kif.keypress = tbl[i].key;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        kif.rdy = 1'b0;

        // Overflow: five digits then ENTER is a mismatch
        for (int i = 1; i <= 5; i++) press(4'(i));
        press(4'd9);
        chk("ovf_err", led_err, 1'b1);
        chk("ovf_fail", fail_cnt, 4'(c_LK));
        measure("ovf_err_len", 1, 4, 1'b0);

`ifdef KEYLOCK_LOCKOUT_EN
        enter_code(16'h1111, 4'd9);
        chk("wrong2_err", led_err, 1'b1);
        chk("wrong2_fail", fail_cnt, 4'd2);
        measure("wrong2_len", 1, 4, 1'b0);
        enter_code(16'h1111, 4'd9);
        chk("wrong3_lockout", lockout, 1'b1);
        chk("wrong3_err", led_err, 1'b1);
        chk("wrong3_fail", fail_cnt, 4'd3);
        measure("lockout_len", 2, 16, 1'b1);
        chk("lockout_fail_clr", fail_cnt, 4'd0);
`else
        for (int t = 2; t <= 5; t++) begin
            enter_code(16'h1111, 4'd9);
            chk($sformatf("wrong%0d_err", t), led_err, 1'b1);
            chk($sformatf("wrong%0d_lockout", t), lockout, 1'b0);
            chk($sformatf("wrong%0d_fail", t), fail_cnt, 4'd0);
            measure($sformatf("wrong%0d_len", t), 1, 4, 1'b0);
        end
`endif

        // Confirmation mismatch leaves the stored code at 1234
        press(4'd8);
        chk("prog_old", led_prog, 1'b1);
        enter_code(16'h1234, 4'd8);
        chk("prog_new", led_prog, 1'b1);
        enter_code(16'h5566, 4'd8);
        chk("prog_conf", led_prog, 1'b1);
        enter_code(16'h5560, 4'd8);
        chk("conf_bad_err", led_err, 1'b1);
        chk("conf_bad_fail", fail_cnt, 4'd0);
        measure("conf_bad_len", 1, 4, 1'b0);
        enter_code(16'h1234, 4'd9);
        chk("old_code_ok", led_ok, 1'b1);
        chk("old_code_locked", locked, 1'b1);
        measure("old_code_len", 0, 4, 1'b1);
        enter_code(16'h1234, 4'd9);
        chk("old_code_unlocked", locked, 1'b0);
        measure("old_code_len2", 0, 4, 1'b0);

        // Successful reprogram to 5566
        press(4'd8);
        enter_code(16'h1234, 4'd8);
        enter_code(16'h5566, 4'd8);
        enter_code(16'h5566, 4'd8);
        chk("prog_ok", led_ok, 1'b1);
        chk("prog_ok_locked", locked, 1'b0);
        measure("prog_ok_len", 0, 4, 1'b0);
        enter_code(16'h5566, 4'd9);
        chk("new_code_locked", locked, 1'b1);
        measure("new_code_len", 0, 4, 1'b0);
        enter_code(16'h1234, 4'd9);
        chk("stale_code_err", led_err, 1'b1);
        chk("stale_code_fail", fail_cnt, 4'(c_LK));
        measure("stale_code_len", 1, 4, 1'b0);
        press(4'd8);
        chk("prog_locked_err", led_err, 1'b1);
        chk("prog_locked_fail", fail_cnt, 4'(c_LK));
        measure("prog_locked_len", 1, 4, 1'b0);
        press(4'd5);
        press(4'd5);
        press(4'd7);
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_err", led_err, 1'b0);
        chk("cancel_fail", fail_cnt, 4'(c_LK));
        enter_code(16'h5566, 4'd9);
        chk("unlock_new", locked, 1'b0);
        chk("unlock_fail_clr", fail_cnt, 4'd0);
        measure("unlock_new_len", 0, 4, 1'b0);

        // Reset in PROG_CONF restores the reset code
        press(4'd8);
        enter_code(16'h5566, 4'd8);
        enter_code(16'h1111, 4'd8);
        chk("pre_reset_prog", led_prog, 1'b1);
        #2 resetN = 1'b0;
        #1 chk("async_reset_outs", outs(), 11'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", outs(), 11'd0);
        enter_code(16'h1234, 4'd9);
        chk("restored_ok", led_ok, 1'b1);
        chk("restored_locked", locked, 1'b1);
        measure("restored_len", 0, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
